// File: rtl/ps2_pkg.sv
// Shared constants, FSM state type and key-word layout for the PS/2 keyboard receiver.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam int KEY_W        = 16;
  localparam int KEY_CNT_MSB  = 15;
  localparam int KEY_CNT_LSB  = 12;
  localparam int KEY_BRK_BIT  = 9;
  localparam int KEY_EXT_BIT  = 8;
  localparam int KEY_CODE_MSB = 7;

  function automatic logic [KEY_W-1:0] pack_key(input logic [3:0] cnt, input logic brk,
                                               input logic ext, input logic [7:0] code);
    logic [KEY_W-1:0] k;
    k = '0;
    k[KEY_CNT_MSB:KEY_CNT_LSB] = cnt;
    k[KEY_BRK_BIT]             = brk;
    k[KEY_EXT_BIT]             = ext;
    k[KEY_CODE_MSB:0]          = code;
    return k;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Two-flop synchroniser followed by an all-equal history filter; emits a one-cycle
// strobe on each filtered high-to-low transition of the PS/2 clock.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic fall
);

  logic                  sync_p0;
  logic                  sync_p1;
  logic [FILTER_LEN-1:0] hist;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      hist    <= '1;
      level   <= 1'b1;
    end else begin
      sync_p0 <= pin;
      sync_p1 <= sync_p0;
      hist    <= {hist[FILTER_LEN-2:0], sync_p1};
      if (&hist)
        level <= 1'b1;
      else if (~|hist)
        level <= 1'b0;
    end
  end

  // High for exactly the one cycle between the history going all-zero and level dropping.
  assign fall = level & ~|hist;

endmodule

// File: rtl/ps2_keycode.sv
// PS/2 device-to-host frame receiver that folds E0/F0 prefixes into a 16-bit key word
// carrying a wrapping 4-bit event count for polling firmware.
module ps2_keycode
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  output logic [KEY_W-1:0]  key,
  output logic              key_valid,
  output logic              frame_err
);

  localparam int TO_W = $clog2(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYC - 1);

  logic            fall;
  logic            clk_level_unused;
  logic            data_p0;
  logic            data_p1;
  ps2_state_t      state;
  ps2_state_t      state_nxt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            par_bit;
  logic [TO_W-1:0] idle_cnt;
  logic            ext_f;
  logic            brk_f;
  logic [3:0]      cnt;
  logic            timeout;
  logic            stop_good;
  logic            byte_done;
  logic            byte_bad;
  logic            is_ext;
  logic            is_brk;
  logic            emit;
  logic            err_evt;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk   (clk),
    .rst   (rst),
    .pin   (ps2_clk),
    .level (clk_level_unused),
    .fall  (fall)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_p0 <= 1'b1;
      data_p1 <= 1'b1;
    end else begin
      data_p0 <= ps2_data;
      data_p1 <= data_p0;
    end
  end

  // A fall in the same cycle as the limit counts as activity, so the frame carries on.
  assign timeout   = (state != IDLE) && !fall && (idle_cnt == TO_LIMIT);
  assign stop_good = (^{par_bit, shreg}) & data_p1;

  always_comb begin
    state_nxt = state;
    byte_done = 1'b0;
    byte_bad  = 1'b0;
    if (timeout) begin
      state_nxt = IDLE;
    end else if (fall) begin
      case (state)
        IDLE:    if (!data_p1) state_nxt = DATA;
        DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
        PARITY:  state_nxt = STOP;
        STOP: begin
          state_nxt = IDLE;
          if (stop_good) byte_done = 1'b1;
          else           byte_bad  = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign is_ext  = byte_done && (shreg == PS2_EXT);
  assign is_brk  = byte_done && (shreg == PS2_BRK);
  assign emit    = byte_done && !is_ext && !is_brk;
  assign err_evt = byte_bad || timeout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      idle_cnt  <= '0;
      ext_f     <= 1'b0;
      brk_f     <= 1'b0;
      cnt       <= 4'd0;
      key       <= '0;
      key_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      key_valid <= emit;
      frame_err <= err_evt;
      if (state == IDLE || fall)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + 1'b1;
      if (err_evt) begin
        ext_f <= 1'b0;
        brk_f <= 1'b0;
      end else if (emit) begin
        key   <= pack_key(cnt + 4'd1, brk_f, ext_f, shreg);
        cnt   <= cnt + 4'd1;
        ext_f <= 1'b0;
        brk_f <= 1'b0;
      end else if (is_ext) begin
        ext_f <= 1'b1;
      end else if (is_brk) begin
        brk_f <= 1'b1;
      end
    end
  end

  // Frame shift path: only meaningful while a frame is in flight, so it carries no reset.
  always_ff @(posedge clk) begin
    if (fall) begin
      case (state)
        IDLE:   bit_cnt <= 3'd0;
        DATA: begin
          shreg   <= {data_p1, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
        PARITY: par_bit <= data_p1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_keycode.sv
// Bench for ps2_keycode: bit-level PS/2 frame driver, event scoreboard and a table of frames.
module tb_ps2_keycode;
  import ps2_pkg::*;

  localparam int FILTER_LEN  = 4;
  localparam int TIMEOUT_CYC = 200;
  localparam int HALF        = 40;

  logic        clk;
  logic        rst;
  logic        ps2_clk;
  logic        ps2_data;
  logic [15:0] key;
  logic        key_valid;
  logic        frame_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          is_err;
    logic [15:0] key;
  } ev_t;
  ev_t sbq[$];

  typedef struct {
    bit          do_rst;
    logic [7:0]  code;
    bit          good;
    int          kind;
    logic [15:0] exp_key;
  } vec_t;
  vec_t tbl[11];

  ps2_keycode #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .key       (key),
    .key_valid (key_valid),
    .frame_err (frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && (key_valid || frame_err)) begin
      ev_t e;
      if (key_valid && frame_err) begin
        check("valid_and_err_together", 32'd1, 32'd0);
      end else if (sbq.size() == 0) begin
        check("unexpected_event", {30'd0, frame_err, key_valid}, 32'd0);
      end else begin
        e = sbq.pop_front();
        check(e.is_err ? "err_pulse" : "valid_pulse", {31'd0, frame_err}, {31'd0, e.is_err});
        check("event_key", {16'd0, key}, {16'd0, e.key});
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_key_in_reset", {16'd0, key}, 32'd0);
    rst = 1'b1;
    sbq.delete();
    repeat (3) @(negedge clk);
    check("rst_key", {16'd0, key}, 32'd0);
    check("rst_valid", {31'd0, key_valid}, 32'd0);
    check("rst_err", {31'd0, frame_err}, 32'd0);
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    @(negedge clk);
    ps2_data = b;
    repeat (HALF / 2) @(negedge clk);
    if (glitch) begin
      ps2_clk = 1'b0;
      repeat (2) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (8) @(negedge clk);
    end
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF / 2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit good_par, input bit glitch);
    logic par;
    par = good_par ? ~^b : ^b;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch && (i == 3));
    send_bit(par, 1'b0);
    send_bit(1'b1, 1'b0);
    repeat (10) @(negedge clk);
  endtask

  task automatic push(input bit is_err, input logic [15:0] k);
    ev_t e;
    e.is_err = is_err;
    e.key    = k;
    sbq.push_back(e);
  endtask

  initial begin
    logic [7:0] code;
    logic [7:0] part;
    rst      = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;

    tbl[0]  = '{1'b1, 8'h1C, 1'b1, 1, 16'h101C};
    tbl[1]  = '{1'b1, 8'hE0, 1'b1, 0, 16'h0000};
    tbl[2]  = '{1'b0, 8'hF0, 1'b1, 0, 16'h0000};
    tbl[3]  = '{1'b0, 8'h75, 1'b1, 1, 16'h1375};
    tbl[4]  = '{1'b1, 8'h1C, 1'b0, 2, 16'h0000};
    tbl[5]  = '{1'b0, 8'h1B, 1'b1, 1, 16'h101B};
    tbl[6]  = '{1'b0, 8'hF0, 1'b1, 0, 16'h0000};
    tbl[7]  = '{1'b0, 8'h1C, 1'b1, 1, 16'h221C};
    tbl[8]  = '{1'b0, 8'hE0, 1'b1, 0, 16'h0000};
    tbl[9]  = '{1'b0, 8'h1C, 1'b0, 2, 16'h221C};
    tbl[10] = '{1'b0, 8'h29, 1'b1, 1, 16'h3029};

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].do_rst) apply_reset();
      if (tbl[i].kind != 0) push(tbl[i].kind == 2, tbl[i].exp_key);
      send_frame(tbl[i].code, tbl[i].good, 1'b0);
      check($sformatf("tbl%0d_drain", i), sbq.size(), 32'd0);
    end

    // Timeout after a prefix: abort mid-frame, flags must be cleared.
    apply_reset();
    send_frame(8'hE0, 1'b1, 1'b0);
    push(1'b1, 16'h0000);
    part = 8'h74;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(part[i], 1'b0);
    repeat (250) @(negedge clk);
    check("timeout_drain", sbq.size(), 32'd0);
    check("timeout_idle", {30'd0, dut.state}, {30'd0, IDLE});
    push(1'b0, 16'h1074);
    send_frame(8'h74, 1'b1, 1'b0);
    check("after_timeout_drain", sbq.size(), 32'd0);

    // Counter wrap with clock glitches injected in some frames.
    apply_reset();
    for (int i = 0; i < 17; i++) begin
      code = 8'h15 + 8'(i);
      push(1'b0, {4'(i + 1), 4'h0, code});
      send_frame(code, 1'b1, (i % 3) == 1);
    end
    check("wrap_drain", sbq.size(), 32'd0);
    check("wrap_cnt", {28'd0, key[15:12]}, 32'd1);
    check("wrap_code", {24'd0, key[7:0]}, 32'h25);

    // Reset in the middle of a frame drops it.
    apply_reset();
    part = 8'h5A;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(part[i], 1'b0);
    apply_reset();
    push(1'b0, 16'h1029);
    send_frame(8'h29, 1'b1, 1'b0);
    check("midrst_drain", sbq.size(), 32'd0);
    check("midrst_key", {16'd0, key}, 32'h1029);

    repeat (20) @(negedge clk);
    check("final_drain", sbq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
